mux2_arbiter: RTL and testbench

MUX2_ARBITER -- requirements
Module: mux2_arbiter

---
 rtl/mux2_arbiter.sv | 117 +++++++++++
 tb/tb_mux2_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux2_arbiter.sv
// mux2_arbiter: two-requester round-robin arbiter driving a registered-select 2:1 data mux.
// Optional forced revocation of a long-held grant is enabled by defining ARB_TIMEOUT_EN.
module mux2_arbiter #(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_a,
    input  logic              req_b,
    input  logic [DATA_W-1:0] data_a,
    input  logic [DATA_W-1:0] data_b,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic              sel,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   ptr_b;      // 1 when B was granted most recently, so A wins the next tie
    logic   force_sw;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             own_req;
    logic             other_req;
    logic             timeout_q;

    always_comb begin
        own_req   = 1'b0;
        other_req = 1'b0;
        if (state == OWN_A) begin
            own_req   = req_a;
            other_req = req_b;
        end else if (state == OWN_B) begin
            own_req   = req_b;
            other_req = req_a;
        end
        force_sw = other_req && (cnt == CNT_W'(TIMEOUT - 1));
        cnt_nxt  = (state_nxt != state || !other_req) ? '0 : cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            timeout_q <= force_sw && own_req;
        end
    end

    assign timeout = timeout_q;
`else
    assign force_sw = 1'b0;
    assign timeout  = 1'b0;
`endif

    // Release and forced revocation share one path: hand over if the other side waits.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_a && req_b) state_nxt = ptr_b ? OWN_A : OWN_B;
                else if (req_a)     state_nxt = OWN_A;
                else if (req_b)     state_nxt = OWN_B;
            end
            OWN_A: begin
                if (!req_a || force_sw) state_nxt = req_b ? OWN_B : IDLE;
            end
            OWN_B: begin
                if (!req_b || force_sw) state_nxt = req_a ? OWN_A : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr_b <= 1'b1;
            sel   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt == OWN_A) begin
                ptr_b <= 1'b0;
                sel   <= 1'b0;
            end else if (state_nxt == OWN_B) begin
                ptr_b <= 1'b1;
                sel   <= 1'b1;
            end
        end
    end

    assign gnt_a     = (state == OWN_A);
    assign gnt_b     = (state == OWN_B);
    assign out_valid = gnt_a | gnt_b;

    always_comb begin
        out_data = '0;
        if (gnt_a)      out_data = data_a;
        else if (gnt_b) out_data = data_b;
    end

endmodule

// File: tb/tb_mux2_arbiter.sv
// Self-checking bench for mux2_arbiter: directed scenarios plus randomized traffic
// checked against an owner/last-winner reference model.
module tb_mux2_arbiter;

    localparam int DATA_W = 8;
`ifdef ARB_TIMEOUT_EN
    localparam int TIMEOUT = 4;
`else
    localparam int TIMEOUT = 16;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_a = 1'b0;
    logic              req_b = 1'b0;
    logic [DATA_W-1:0] data_a = '0;
    logic [DATA_W-1:0] data_b = '0;
    logic              gnt_a, gnt_b, sel, out_valid, timeout;
    logic [DATA_W-1:0] out_data;

    int n_chk  = 0;
    int n_pass = 0;
    bit mon_en = 1'b0;

    // reference model: owner 0=none 1=A 2=B, last = most recent winner
    int m_owner, m_last, m_wait;
    bit m_sel, m_to;

    mux2_arbiter #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b),
        .data_a(data_a), .data_b(data_b), .gnt_a(gnt_a), .gnt_b(gnt_b),
        .sel(sel), .out_valid(out_valid), .out_data(out_data), .timeout(timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_en) begin
            n_chk++;
            if ((gnt_a & gnt_b) !== 1'b0)
                $display("FAIL excl: gnt_a=%b gnt_b=%b, required not both 1", gnt_a, gnt_b);
            else n_pass++;
            n_chk++;
            if (out_valid !== (gnt_a | gnt_b))
                $display("FAIL valid_or: out_valid=%b, required %b", out_valid, gnt_a | gnt_b);
            else n_pass++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        tick();
        rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0;
        #10;
        rst_n = 1'b1;
        m_owner = 0; m_last = 2; m_wait = 0; m_sel = 1'b0; m_to = 1'b0;
    endtask

    function automatic void model_step(input bit ra, input bit rb);
        int nxt;
        bit mine, other, forced;
        forced = 1'b0;
        mine   = (m_owner == 1) ? ra : rb;
        other  = (m_owner == 1) ? rb : ra;
        if (m_owner == 0) begin
            if (ra && rb)  nxt = (m_last == 2) ? 1 : 2;
            else if (ra)   nxt = 1;
            else if (rb)   nxt = 2;
            else           nxt = 0;
            other = 1'b0;
        end else if (!mine) begin
            nxt = other ? 3 - m_owner : 0;
        end else begin
            nxt = m_owner;
`ifdef ARB_TIMEOUT_EN
            if (other && m_wait == TIMEOUT - 1) begin
                nxt    = 3 - m_owner;
                forced = 1'b1;
            end
`endif
        end
        if (nxt != m_owner || !other) m_wait = 0;
        else                          m_wait = m_wait + 1;
        if (nxt != 0) begin
            m_last = nxt;
            m_sel  = (nxt == 2);
        end
        m_owner = nxt;
        m_to    = forced;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_chk++; if (gnt_a !== 1'b0) $display("FAIL rst_gnt_a: got %b, required 0", gnt_a); else n_pass++;
        n_chk++; if (gnt_b !== 1'b0) $display("FAIL rst_gnt_b: got %b, required 0", gnt_b); else n_pass++;
        n_chk++; if (sel !== 1'b0) $display("FAIL rst_sel: got %b, required 0", sel); else n_pass++;
        n_chk++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b, required 0", out_valid); else n_pass++;
        n_chk++; if (out_data !== 8'h00) $display("FAIL rst_data: got %h, required 00", out_data); else n_pass++;
        n_chk++; if (timeout !== 1'b0) $display("FAIL rst_timeout: got %b, required 0", timeout); else n_pass++;
        mon_en = 1'b1;
    endtask

    task automatic test_single_grant();
        apply_reset();
        req_a = 1'b1; data_a = 8'h5A;
        tick();
        n_chk++; if (gnt_a !== 1'b1) $display("FAIL single_gnt_a: got %b, required 1", gnt_a); else n_pass++;
        n_chk++; if (gnt_b !== 1'b0) $display("FAIL single_gnt_b: got %b, required 0", gnt_b); else n_pass++;
        n_chk++; if (sel !== 1'b0) $display("FAIL single_sel: got %b, required 0", sel); else n_pass++;
        n_chk++; if (out_valid !== 1'b1) $display("FAIL single_valid: got %b, required 1", out_valid); else n_pass++;
        n_chk++; if (out_data !== 8'h5A) $display("FAIL single_data: got %h, required 5a", out_data); else n_pass++;
    endtask

    task automatic test_tie_handover();
        apply_reset();
        req_a = 1'b1; req_b = 1'b1;
        tick();
        n_chk++; if ({gnt_a, gnt_b} !== 2'b10) $display("FAIL tie_first: gnt_a,gnt_b=%b, required 10", {gnt_a, gnt_b}); else n_pass++;
        req_a = 1'b0;
        tick();
        n_chk++; if ({gnt_a, gnt_b} !== 2'b01) $display("FAIL handover: gnt_a,gnt_b=%b, required 01", {gnt_a, gnt_b}); else n_pass++;
        n_chk++; if (sel !== 1'b1) $display("FAIL handover_sel: got %b, required 1", sel); else n_pass++;
        req_b = 1'b0;
        tick();
        n_chk++; if (out_valid !== 1'b0) $display("FAIL tie_idle: out_valid=%b, required 0", out_valid); else n_pass++;
        req_a = 1'b1; req_b = 1'b1;
        tick();
        n_chk++; if ({gnt_a, gnt_b} !== 2'b10) $display("FAIL tie_again: gnt_a,gnt_b=%b, required 10", {gnt_a, gnt_b}); else n_pass++;
        n_chk++; if (sel !== 1'b0) $display("FAIL tie_again_sel: got %b, required 0", sel); else n_pass++;
        req_a = 1'b0; req_b = 1'b0;
    endtask

    task automatic test_release_idle();
        apply_reset();
        req_b = 1'b1; data_b = 8'hC3;
        tick();
        n_chk++; if (out_data !== 8'hC3) $display("FAIL own_b_data: got %h, required c3", out_data); else n_pass++;
        n_chk++; if (sel !== 1'b1) $display("FAIL own_b_sel: got %b, required 1", sel); else n_pass++;
        req_b = 1'b0;
        tick();
        n_chk++; if (out_valid !== 1'b0) $display("FAIL rel_valid: got %b, required 0", out_valid); else n_pass++;
        n_chk++; if (out_data !== 8'h00) $display("FAIL rel_data: got %h, required 00", out_data); else n_pass++;
        n_chk++; if (sel !== 1'b1) $display("FAIL rel_sel: got %b, required 1", sel); else n_pass++;
        tick();
        n_chk++; if (sel !== 1'b1) $display("FAIL idle_sel_hold: got %b, required 1", sel); else n_pass++;
    endtask

    task automatic test_timeout();
        apply_reset();
        req_a = 1'b1; req_b = 1'b1;
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            tick();
            n_chk++;
            if (gnt_a !== 1'b1 || timeout !== 1'b0)
                $display("FAIL to_hold[%0d]: gnt_a=%b timeout=%b, required 1 0", i, gnt_a, timeout);
            else n_pass++;
        end
        tick();
        n_chk++; if ({gnt_a, gnt_b} !== 2'b01) $display("FAIL to_switch: gnt_a,gnt_b=%b, required 01", {gnt_a, gnt_b}); else n_pass++;
        n_chk++; if (timeout !== 1'b1) $display("FAIL to_pulse: got %b, required 1", timeout); else n_pass++;
        tick();
        n_chk++; if (timeout !== 1'b0) $display("FAIL to_pulse_end: got %b, required 0", timeout); else n_pass++;
        n_chk++; if (gnt_b !== 1'b1) $display("FAIL to_b_hold: got %b, required 1", gnt_b); else n_pass++;
`else
        for (int i = 0; i < 100; i++) begin
            tick();
            n_chk++;
            if (gnt_a !== 1'b1 || timeout !== 1'b0)
                $display("FAIL no_to_hold[%0d]: gnt_a=%b timeout=%b, required 1 0", i, gnt_a, timeout);
            else n_pass++;
        end
`endif
        req_a = 1'b0; req_b = 1'b0;
    endtask

    task automatic test_async_reset();
        apply_reset();
        req_b = 1'b1;
        tick();
        n_chk++; if (gnt_b !== 1'b1) $display("FAIL ar_own_b: got %b, required 1", gnt_b); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++; if (gnt_b !== 1'b0) $display("FAIL ar_gnt_b: got %b, required 0", gnt_b); else n_pass++;
        n_chk++; if (sel !== 1'b0) $display("FAIL ar_sel: got %b, required 0", sel); else n_pass++;
        #2;
        rst_n = 1'b1;
        tick();
        n_chk++; if (gnt_b !== 1'b1) $display("FAIL ar_regrant: got %b, required 1", gnt_b); else n_pass++;
        req_b = 1'b0;
    endtask

    task automatic test_random();
        bit ra, rb;
        logic [DATA_W-1:0] exp_data;
        apply_reset();
        ra = 1'b0; rb = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) ra = ~ra;
            if ($urandom_range(0, 3) == 0) rb = ~rb;
            req_a = ra; req_b = rb;
            data_a = DATA_W'($urandom); data_b = DATA_W'($urandom);
            tick();
            model_step(ra, rb);
            exp_data = (m_owner == 1) ? data_a : (m_owner == 2) ? data_b : '0;
            n_chk++;
            if ({gnt_a, gnt_b} !== {m_owner == 1, m_owner == 2})
                $display("FAIL rnd_gnt[%0d]: gnt_a,gnt_b=%b, required %b", i, {gnt_a, gnt_b}, {m_owner == 1, m_owner == 2});
            else n_pass++;
            n_chk++;
            if (sel !== m_sel) $display("FAIL rnd_sel[%0d]: got %b, required %b", i, sel, m_sel); else n_pass++;
            n_chk++;
            if (out_data !== exp_data) $display("FAIL rnd_data[%0d]: got %h, required %h", i, out_data, exp_data); else n_pass++;
            n_chk++;
            if (timeout !== m_to) $display("FAIL rnd_timeout[%0d]: got %b, required %b", i, timeout, m_to); else n_pass++;
        end
        req_a = 1'b0; req_b = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_grant();
        test_tie_handover();
        test_release_idle();
        test_timeout();
        test_async_reset();
        test_random();
        tick();
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
